// File: rtl/alu32_pkg.sv
// Shared definitions for the ALU32 arbiter slice.
// Contents: bus widths, 11-bit ALU op codes, op_legal() helper, arbiter
// state enum and the packed response payload.
package alu32_pkg;

    localparam int unsigned OP_W     = 11;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NREQ_DEF = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 11'h020;
    localparam logic [OP_W-1:0] OP_ADDU = 11'h021;
    localparam logic [OP_W-1:0] OP_SUB  = 11'h022;
    localparam logic [OP_W-1:0] OP_SUBU = 11'h023;
    localparam logic [OP_W-1:0] OP_AND  = 11'h024;
    localparam logic [OP_W-1:0] OP_OR   = 11'h025;
    localparam logic [OP_W-1:0] OP_XOR  = 11'h026;
    localparam logic [OP_W-1:0] OP_NOR  = 11'h027;
    localparam logic [OP_W-1:0] OP_SLT  = 11'h02A;
    localparam logic [OP_W-1:0] OP_SLTU = 11'h02B;
    localparam logic [OP_W-1:0] OP_SHL  = 11'h004;
    localparam logic [OP_W-1:0] OP_SHR  = 11'h006;
    localparam logic [OP_W-1:0] OP_SAR  = 11'h007;

    // Response slot occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    // Registered response payload (id is carried separately, its width is a parameter).
    typedef struct packed {
        logic [DATA_W-1:0] out;
        logic              carry;
        logic              ovf;
        logic              zero;
        logic              err;
    } alu_rsp_t;

    // True for every op code ALU32 implements.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
            OP_AND, OP_OR, OP_XOR, OP_NOR,
            OP_SLT, OP_SLTU,
            OP_SHL, OP_SHR, OP_SAR: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu32_arbiter_if.sv
// Request/response bus of the ALU32 arbiter.
// master: requesters + response consumer (drive req_valid/op/a/b, rsp_ready).
// slave : the arbiter (drives req_ready and all rsp_* signals).
// req_op/req_a/req_b are flattened: requester i sits at [i*W +: W].
interface alu32_arbiter_if
    import alu32_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = 2
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*OP_W-1:0]   req_op;
    logic [NREQ*DATA_W-1:0] req_a;
    logic [NREQ*DATA_W-1:0] req_b;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [DATA_W-1:0]      rsp_out;
    logic                   rsp_carry;
    logic                   rsp_ovf;
    logic                   rsp_zero;
    logic                   rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_out,
               rsp_carry, rsp_ovf, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_out,
               rsp_carry, rsp_ovf, rsp_zero, rsp_err
    );

endinterface

// File: rtl/ALU32.sv
// Combinational 32-bit ALU shared by the arbiter.
// Ports (in order): op[10:0], in0[31:0], in1[31:0], carryout, overflow, zero, out[31:0].
// carryout is the adder carry for add/addu/sub/subu (sub computes in0 + ~in1 + 1),
// overflow is signed overflow for add/sub only, zero is (out == 0) for every op.
// Shift ops shift in0 by in1[4:0]. Unknown ops yield out = 0.
module ALU32
    import alu32_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    output logic              carryout,
    output logic              overflow,
    output logic              zero,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W:0] sum_c;
    logic [DATA_W:0] diff_c;
    logic [4:0]      shamt_c;

    assign sum_c   = {1'b0, in0} + {1'b0, in1};
    assign diff_c  = {1'b0, in0} + {1'b0, ~in1} + 33'd1;
    assign shamt_c = in1[4:0];

    // Result and flag selection.
    always_comb begin
        out      = '0;
        carryout = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                out      = sum_c[DATA_W-1:0];
                carryout = sum_c[DATA_W];
                overflow = (in0[31] == in1[31]) && (sum_c[31] != in0[31]);
            end
            OP_ADDU: begin
                out      = sum_c[DATA_W-1:0];
                carryout = sum_c[DATA_W];
            end
            OP_SUB: begin
                out      = diff_c[DATA_W-1:0];
                carryout = diff_c[DATA_W];
                overflow = (in0[31] != in1[31]) && (diff_c[31] != in0[31]);
            end
            OP_SUBU: begin
                out      = diff_c[DATA_W-1:0];
                carryout = diff_c[DATA_W];
            end
            OP_AND:  out = in0 & in1;
            OP_OR:   out = in0 | in1;
            OP_XOR:  out = in0 ^ in1;
            OP_NOR:  out = ~(in0 | in1);
            OP_SLT:  out = {31'd0, ($signed(in0) < $signed(in1))};
            OP_SLTU: out = {31'd0, (in0 < in1)};
            OP_SHL:  out = in0 << shamt_c;
            OP_SHR:  out = in0 >> shamt_c;
            OP_SAR:  out = DATA_W'($signed(in0) >>> shamt_c);
            default: out = '0;
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted req at or above ptr, wrapping to 0.
// Ports: req[NREQ] requests, ptr[IDW] search start; grant[NREQ] one-hot
// (all zero when no request), idx[IDW] encoded winner (0 when none).
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic found;

    // Pass 1 scans ptr..NREQ-1, pass 2 wraps and scans from 0.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= 32'(ptr))) begin
                grant[i] = 1'b1;
                idx      = IDW'(i);
                found    = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                idx      = IDW'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu32_arbiter.sv
// Shares one ALU32 among NREQ requesters with round-robin arbitration and a
// single one-deep registered response slot (latency 1, 1 op/cycle).
// Ports: clk, rst (async, active-high), bus (alu32_arbiter_if.slave):
//   req_valid/req_ready/req_op/req_a/req_b per requester,
//   rsp_valid/rsp_ready/rsp_id/rsp_out/rsp_carry/rsp_ovf/rsp_zero/rsp_err.
// Build option: define ALU_ARB_OPCHK_EN to flag illegal ops via rsp_err
// (result and flags forced to 0); otherwise rsp_err is 0 and any op is forwarded.
module alu32_arbiter
    import alu32_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = 2
) (
    input  logic           clk,
    input  logic           rst,
    alu32_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    alu_rsp_t          rsp_q, rsp_d;

    logic              slot_free_c;
    logic              xfer_c;
    logic [NREQ-1:0]   grant_c;
    logic [IDW-1:0]    gnt_idx_c;

    logic [OP_W-1:0]   sel_op_c;
    logic [DATA_W-1:0] sel_a_c;
    logic [DATA_W-1:0] sel_b_c;

    logic [DATA_W-1:0] alu_out_c;
    logic              alu_carry_c;
    logic              alu_ovf_c;
    logic              alu_zero_c;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (grant_c),
        .idx   (gnt_idx_c)
    );

    // Slot can take a new result when empty or being drained this cycle.
    assign slot_free_c   = (state_q == ST_EMPTY) || bus.rsp_ready;
    assign bus.req_ready = grant_c & {NREQ{slot_free_c & ~rst}};
    assign xfer_c        = |(bus.req_valid & bus.req_ready);

    // AND-OR mux of the granted requester's operands (grant is one-hot).
    always_comb begin
        sel_op_c = '0;
        sel_a_c  = '0;
        sel_b_c  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_c[i]) begin
                sel_op_c = bus.req_op[i*OP_W +: OP_W];
                sel_a_c  = bus.req_a[i*DATA_W +: DATA_W];
                sel_b_c  = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    ALU32 u_alu (
        .op       (sel_op_c),
        .in0      (sel_a_c),
        .in1      (sel_b_c),
        .carryout (alu_carry_c),
        .overflow (alu_ovf_c),
        .zero     (alu_zero_c),
        .out      (alu_out_c)
    );

    // Next state, pointer and response payload.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rsp_id_d = rsp_id_q;
        rsp_d    = rsp_q;

        case (state_q)
            ST_EMPTY: if (xfer_c) state_d = ST_FULL;
            ST_FULL:  if (bus.rsp_ready && !xfer_c) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (xfer_c) begin
            ptr_d     = (gnt_idx_c == IDW'(NREQ - 1)) ? '0 : gnt_idx_c + IDW'(1);
            rsp_id_d  = gnt_idx_c;
            rsp_d.out   = alu_out_c;
            rsp_d.carry = alu_carry_c;
            rsp_d.ovf   = alu_ovf_c;
            rsp_d.zero  = alu_zero_c;
            rsp_d.err   = 1'b0;
`ifdef ALU_ARB_OPCHK_EN
            if (!op_legal(sel_op_c)) begin
                rsp_d     = '0;
                rsp_d.err = 1'b1;
            end
`endif
        end
    end

    // State and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            ptr_q    <= '0;
            rsp_id_q <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rsp_id_q <= rsp_id_d;
            rsp_q    <= rsp_d;
        end
    end

    assign bus.rsp_valid = (state_q == ST_FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_out   = rsp_q.out;
    assign bus.rsp_carry = rsp_q.carry;
    assign bus.rsp_ovf   = rsp_q.ovf;
    assign bus.rsp_zero  = rsp_q.zero;
    assign bus.rsp_err   = rsp_q.err;

endmodule

// File: doc/alu32_arbiter.md
Name: alu32_arbiter

Overview:
- Shares one combinational ALU32 instance between NREQ independent requesters.
- Round-robin arbitration with a valid/ready handshake on each request port.
- A single registered response port carries result, flags and requester id, with backpressure.
- Sits between issue/sequencer logic and the shared ALU32 datapath.

Parameters:
- NREQ, 4, number of requesters; 2..8.
- IDW, 2, width of the requester id; must equal clog2(NREQ), minimum 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept.
- req_op  input  NREQ*11  flattened ALU op codes; requester i at [i*11 +: 11].
- req_a  input  NREQ*32  flattened operand in0.
- req_b  input  NREQ*32  flattened operand in1.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer accept.
- rsp_id  output  IDW  index of the requester served.
- rsp_out  output  32  ALU result.
- rsp_carry, rsp_ovf, rsp_zero  output  1 each  ALU carryout, overflow and zero flags.
- rsp_err  output  1  illegal-op flag; constant 0 unless ALU_ARB_OPCHK_EN is defined.

Behaviour:
- Reset (async, rst=1):
  - rsp_valid, rsp_id, rsp_out, all flags and rsp_err clear to 0.
  - Round-robin pointer resets to 0.
  - req_ready is 0 while rst is high.
  - An in-flight response is discarded.
- slot_free = !rsp_valid | rsp_ready.
- Arbitration (combinational):
  - Grant the first asserted req_valid searching from the pointer upward, wrapping modulo NREQ.
  - req_ready[i] = grant[i] & slot_free. At most one bit is high.
  - req_ready may depend on req_valid. req_valid must not depend on req_ready.
- Transfer: req_valid[i] & req_ready[i] at a clock edge.
  - The granted op/a/b are muxed into ALU32.
  - ALU outputs and id i are registered; rsp_valid=1 on the following cycle (latency 1).
  - Pointer moves to (i+1) mod NREQ.
- No grant in a cycle: pointer unchanged.
- Response hold: while rsp_valid & !rsp_ready, all rsp_* outputs stay stable and no request is accepted.
- Simultaneous drain and accept (rsp_valid & rsp_ready & new transfer): the register loads the new result. Throughput is 1 op/cycle.
- Drain with no new transfer: rsp_valid falls to 0 and the data registers hold their previous value.
- Requester hold rule: a requester keeps valid and operands stable until accepted. The arbiter does not check this.
- Ops are passed unmodified to ALU32. Supported set:
  - 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor
  - 0x2A slt, 0x2B sltu
  - 0x04 shl, 0x06 shr, 0x07 sar
- Flags are exactly the ALU32 outputs for that op.
- FSM (2 states):
  - EMPTY: rsp_valid=0. Goes to FULL on a transfer.
  - FULL: rsp_valid=1. Goes to EMPTY on rsp_ready with no new transfer. Stays FULL otherwise.

Optional Feature:
- Macro: ALU_ARB_OPCHK_EN.
- Defined:
  - An accepted op outside the supported set registers rsp_err=1, rsp_out=0 and all flags 0.
  - The response is still issued with the correct rsp_id.
- Undefined:
  - rsp_err is tied 0.
  - Any op is forwarded and its ALU32 output is returned unmodified.

Decomposition:
- Package alu32_pkg holds:
  - 11-bit op constants: OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_SHL, OP_SHR, OP_SAR.
  - An op_legal function.
  - The NREQ default.
- Sub-module rr_arbiter(NREQ): inputs req and pointer; outputs one-hot grant and encoded index.
- ALU32 is instantiated unmodified, port order (op, in0, in1, carryout, overflow, zero, out).

Test Plan:
- Reset then req0 add a=7fffffff b=70000001, rsp_ready=1 -> next cycle rsp_valid=1, id=0, out=f0000000, ovf=1, carry=0, zero=0.
- All 4 requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0; one response per cycle with ids matching that order.
- req2 sub a=ffffffff b=ffffffff, rsp_ready held 0 for 3 cycles -> rsp_out=0 and zero=1 stable throughout; req_ready=0000 during the hold; accept resumes on the rsp_ready cycle.
- req1 sar a=ffffffff b=3, then sltu a=f0001231 b=7ac34545 back-to-back -> out=ffffffff, then out=00000000.
- Assert rst while rsp_valid=1 -> outputs 0 immediately (asynchronous); after release the first grant goes to requester 0.
- With ALU_ARB_OPCHK_EN defined: req3 op=0x3F -> rsp_err=1, out=0, id=3. Next legal op returns rsp_err=0.
